pkt_xfer_sched: RTL and testbench
=================================

# pkt_xfer_sched

Transfer scheduler for the packet capture datapath. It takes one job from the CSR block: source base, destination base and length in 32-bit words. It splits the job into read bursts (memory → FIFO) for the read controller and write bursts (FIFO → SDRAM/HPS) for the write controller, and gates both on FIFO occupancy so the FIFO never overflows or underflows. It sits between the register block and the two transfer controllers, and exports its state for CSR readback.

## Interface
Parameters:
- `BURST`, 8: maximum words per command (power of two, 1..16).
- `DEPTH`, 512: FIFO capacity in words.
- `LW`, 16: width of the length and counter fields.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-low.
- `start`, in, 1: one-cycle job launch.
- `abort`, in, 1: one-cycle job cancel.
- `src_base`, in, 32: byte address of the first source word (word aligned).
- `dst_base`, in, 32: byte address of the first destination word (word aligned).
- `len_words`, in, LW: job length in words.
- `fifo_usedw`, in, 10: current FIFO fill level.
- `rd_cmd_valid`, out, 1: read-burst command valid.
- `rd_cmd_ready`, in, 1: read controller accepts the command.
- `rd_cmd_addr`, out, 32: read-burst byte address.
- `rd_cmd_len`, out, 5: read-burst length in words.
- `rd_beat`, in, 1: one read word pushed into the FIFO.
- `wr_cmd_valid`, out, 1: write-burst command valid.
- `wr_cmd_ready`, in, 1: write controller accepts the command.
- `wr_cmd_addr`, out, 32: write-burst byte address.
- `wr_cmd_len`, out, 5: write-burst length in words.
- `wr_beat`, in, 1: one word popped from the FIFO and written.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse on successful completion.
- `aborted`, out, 1: sticky flag; cleared by the next accepted `start`.
- `state`, out, 2: IDLE=0, RUN=1, FLUSH=2, ABORT=3.
- `words_done`, out, LW: count of completed write beats for the current job.

## Operation
- Internal registers:
  - `rd_rem`, `wr_rem`: words not yet commanded on each channel.
  - `rd_pend`, `wr_pend`: beats commanded but not yet seen.
  - `rd_addr`, `wr_addr`: next burst addresses.
- IDLE:
  - `start` latches the bases and length, and sets `rd_rem = wr_rem = len_words`.
  - Transition goes to RUN, or to IDLE with a `done` pulse the next cycle if `len_words == 0`.
- RUN, read channel:
  - Eligible when `rd_rem > 0`, `rd_pend == 0`, and `fifo_usedw + min(BURST, rd_rem) <= DEPTH`.
  - Issue sets `rd_cmd_len = min(BURST, rd_rem)` and `rd_cmd_addr = rd_addr`.
  - On handshake: `rd_pend += len`, `rd_rem -= len`, `rd_addr += 4*len`.
- RUN, write channel:
  - Eligible when `wr_rem > 0`, `wr_pend == 0`, and `fifo_usedw >= min(BURST, wr_rem)`.
  - The same accounting applies on the write side.
- At most one outstanding command per channel. The two channels run independently; both may handshake in the same cycle.
- Each `rd_beat` decrements `rd_pend`. Each `wr_beat` decrements `wr_pend` and increments `words_done`.
- RUN → FLUSH when `rd_rem == 0` and `rd_pend == 0`.
- FLUSH issues write commands only.
- FLUSH → IDLE when `wr_rem == 0` and `wr_pend == 0`, with a one-cycle `done` pulse.
- `abort` in RUN or FLUSH:
  - Go to ABORT and deassert any unaccepted `cmd_valid` immediately.
  - Wait until `rd_pend == 0` and `wr_pend == 0`, then go to IDLE, set `aborted`, and do not pulse `done`.
- `start` is ignored outside IDLE.
- `abort` in IDLE is ignored.
- A `start` and `abort` in the same IDLE cycle: `start` wins.
- A beat that arrives with its `pend` already at 0 is ignored (the counter saturates at 0).

## Timing
- Reset values (`reset` low at a clock edge): all outputs 0, `state` = IDLE, all counters and addresses 0. This applies mid-job too; in-flight beats after reset are ignored.
- All outputs are registered.
- `rd_cmd_valid` rises no earlier than the cycle after `start`. First command latency from `start` is 2 cycles, given FIFO credit.
- `cmd_valid`, `addr` and `len` are held stable until `valid & ready`. `valid` drops the cycle after the handshake.
- The next command on a channel is eligible the cycle after its final beat. This gives a minimum one-cycle bubble between bursts.
- Eligibility uses the registered `fifo_usedw` of the current cycle.
- `done` is asserted in the cycle following the final `wr_beat`, coincident with `state` = IDLE and `busy` = 0.
- Address arithmetic is 32-bit modulo (wraps silently).
- Counters are LW-bit and never underflow.

## Test plan
- `src=0x1000`, `dst=0x8000`, `len=20`, `BURST=8`, ready tied high, beats one per cycle → read commands (0x1000,8), (0x1020,8), (0x1040,4); write commands (0x8000,8), (0x8020,8), (0x8040,4); `done` one cycle after the 20th `wr_beat`; `words_done=20`.
- `fifo_usedw` held at 506, `len=8` → no `rd_cmd_valid` until `usedw` drops to 504; then `rd_cmd_len=8`.
- `len=0` → `busy` pulses for one cycle and `done` pulses; no command valid is ever asserted.
- `abort` after the first read burst while 5 beats are pending → `cmd_valid` drops, state=3 until the 5th beat, then IDLE with `aborted=1` and no `done`.
- `start` pulses while in RUN → ignored; the job completes with the original length and addresses.
- `reset` low mid-burst with `rd_cmd_valid=1` → the next cycle shows all outputs 0 and state IDLE; a subsequent `start` runs cleanly.

Source files
------------

// File: rtl/pkt_xfer_sched.sv
// Transfer scheduler: splits one CSR job into read and write bursts and gates
// each channel on FIFO occupancy so the capture FIFO never over/underflows.
module pkt_xfer_sched #(
  parameter int BURST = 8,
  parameter int DEPTH = 512,
  parameter int LW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   src_base,
  input  logic [31:0]   dst_base,
  input  logic [LW-1:0] len_words,
  input  logic [9:0]    fifo_usedw,
  output logic          rd_cmd_valid,
  input  logic          rd_cmd_ready,
  output logic [31:0]   rd_cmd_addr,
  output logic [4:0]    rd_cmd_len,
  input  logic          rd_beat,
  output logic          wr_cmd_valid,
  input  logic          wr_cmd_ready,
  output logic [31:0]   wr_cmd_addr,
  output logic [4:0]    wr_cmd_len,
  input  logic          wr_beat,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [1:0]    state,
  output logic [LW-1:0] words_done
);

  // IDLE | await start ; RUN | both channels ; FLUSH | writes only ; ABORT | drain pending beats
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2, S_ABORT = 2'd3} state_t;

  localparam logic [LW-1:0] BURST_W = LW'(BURST);
  localparam logic [4:0]    BURST_L = 5'(BURST);
  localparam logic [31:0]   DEPTH_W = 32'(DEPTH);
  localparam logic [LW-1:0] ONE     = LW'(1);

  state_t        state_q, state_d;
  logic [LW-1:0] rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
  logic [LW-1:0] rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [31:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic          rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
  logic [31:0]   rd_caddr_q, rd_caddr_d, wr_caddr_q, wr_caddr_d;
  logic [4:0]    rd_len_q, rd_len_d, wr_len_q, wr_len_d;
  logic          busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic [LW-1:0] words_done_q, words_done_d;

  logic          rd_hs, wr_hs, rd_dec, wr_dec, rd_elig, wr_elig;
  logic [4:0]    rd_blen, wr_blen;
  logic [LW-1:0] rd_len_ext, wr_len_ext;

  assign rd_hs      = rd_valid_q & rd_cmd_ready;
  assign wr_hs      = wr_valid_q & wr_cmd_ready;
  // beats with nothing pending are dropped so the counters saturate at zero
  assign rd_dec     = rd_beat & (rd_pend_q != '0);
  assign wr_dec     = wr_beat & (wr_pend_q != '0);
  assign rd_blen    = (rd_rem_q >= BURST_W) ? BURST_L : rd_rem_q[4:0];
  assign wr_blen    = (wr_rem_q >= BURST_W) ? BURST_L : wr_rem_q[4:0];
  assign rd_len_ext = {{(LW-5){1'b0}}, rd_len_q};
  assign wr_len_ext = {{(LW-5){1'b0}}, wr_len_q};
  assign rd_elig    = !rd_valid_q && (rd_rem_q != '0) && (rd_pend_q == '0) &&
                      (({22'd0, fifo_usedw} + {27'd0, rd_blen}) <= DEPTH_W);
  assign wr_elig    = !wr_valid_q && (wr_rem_q != '0) && (wr_pend_q == '0) &&
                      (fifo_usedw >= {5'd0, wr_blen});

  always_comb begin
    state_d      = state_q;
    rd_rem_d     = rd_rem_q;
    wr_rem_d     = wr_rem_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    rd_valid_d   = rd_valid_q;
    wr_valid_d   = wr_valid_q;
    rd_caddr_d   = rd_caddr_q;
    wr_caddr_d   = wr_caddr_q;
    rd_len_d     = rd_len_q;
    wr_len_d     = wr_len_q;
    aborted_d    = aborted_q;
    words_done_d = words_done_q;
    done_d       = 1'b0;

    if (rd_hs) begin
      rd_valid_d = 1'b0;
      rd_rem_d   = rd_rem_q - rd_len_ext;
      rd_addr_d  = rd_addr_q + {25'd0, rd_len_q, 2'b00};
    end
    if (wr_hs) begin
      wr_valid_d = 1'b0;
      wr_rem_d   = wr_rem_q - wr_len_ext;
      wr_addr_d  = wr_addr_q + {25'd0, wr_len_q, 2'b00};
    end
    rd_pend_d = rd_pend_q + (rd_hs ? rd_len_ext : '0) - (rd_dec ? ONE : '0);
    wr_pend_d = wr_pend_q + (wr_hs ? wr_len_ext : '0) - (wr_dec ? ONE : '0);
    if (wr_dec) words_done_d = words_done_q + ONE;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_addr_d    = src_base;
          wr_addr_d    = dst_base;
          rd_rem_d     = len_words;
          wr_rem_d     = len_words;
          rd_pend_d    = '0;
          wr_pend_d    = '0;
          words_done_d = '0;
          aborted_d    = 1'b0;
          state_d      = S_RUN;
        end
      end
      S_RUN, S_FLUSH: begin
        if (abort) begin
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          state_d    = S_ABORT;
        end else begin
          if (rd_elig && state_q == S_RUN) begin
            rd_valid_d = 1'b1;
            rd_len_d   = rd_blen;
            rd_caddr_d = rd_addr_q;
          end
          if (wr_elig) begin
            wr_valid_d = 1'b1;
            wr_len_d   = wr_blen;
            wr_caddr_d = wr_addr_q;
          end
          // a zero-length job drains both channels at once and skips FLUSH
          if (wr_rem_d == '0 && wr_pend_d == '0 && rd_rem_d == '0 && rd_pend_d == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (state_q == S_RUN && rd_rem_d == '0 && rd_pend_d == '0) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_ABORT: begin
        if (rd_pend_d == '0 && wr_pend_d == '0) begin
          rd_rem_d  = '0;
          wr_rem_d  = '0;
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rd_rem_q     <= '0;
      wr_rem_q     <= '0;
      rd_pend_q    <= '0;
      wr_pend_q    <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
      wr_valid_q   <= 1'b0;
      rd_caddr_q   <= '0;
      wr_caddr_q   <= '0;
      rd_len_q     <= '0;
      wr_len_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_rem_q     <= rd_rem_d;
      wr_rem_q     <= wr_rem_d;
      rd_pend_q    <= rd_pend_d;
      wr_pend_q    <= wr_pend_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      rd_valid_q   <= rd_valid_d;
      wr_valid_q   <= wr_valid_d;
      rd_caddr_q   <= rd_caddr_d;
      wr_caddr_q   <= wr_caddr_d;
      rd_len_q     <= rd_len_d;
      wr_len_q     <= wr_len_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      words_done_q <= words_done_d;
    end
  end

  assign rd_cmd_valid = rd_valid_q;
  assign rd_cmd_addr  = rd_caddr_q;
  assign rd_cmd_len   = rd_len_q;
  assign wr_cmd_valid = wr_valid_q;
  assign wr_cmd_addr  = wr_caddr_q;
  assign wr_cmd_len   = wr_len_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign state        = state_q;
  assign words_done   = words_done_q;

endmodule

// File: tb/tb_pkt_xfer_sched.sv
// Directed bench for pkt_xfer_sched: burst splitting, FIFO gating, zero length,
// abort draining, ignored restart, mid-job reset and address wrap.
module tb_pkt_xfer_sched;
  localparam int LW    = 16;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [31:0]   src_base, dst_base;
  logic [LW-1:0] len_words;
  logic [9:0]    fifo_usedw;
  logic          rd_cmd_valid, rd_cmd_ready, rd_beat;
  logic [31:0]   rd_cmd_addr;
  logic [4:0]    rd_cmd_len;
  logic          wr_cmd_valid, wr_cmd_ready, wr_beat;
  logic [31:0]   wr_cmd_addr;
  logic [4:0]    wr_cmd_len;
  logic          busy, done, aborted;
  logic [1:0]    state;
  logic [LW-1:0] words_done;

  int n_checks = 0;
  int n_err    = 0;

  pkt_xfer_sched #(.BURST(8), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .len_words(len_words),
    .fifo_usedw(fifo_usedw),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len), .rd_beat(rd_beat),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .wr_beat(wr_beat),
    .busy(busy), .done(done), .aborted(aborted), .state(state),
    .words_done(words_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // results of the last run_job
  logic [31:0]   rd_a [8];
  logic [31:0]   wr_a [8];
  logic [4:0]    rd_l [8];
  logic [4:0]    wr_l [8];
  int            n_rd, n_wr, n_done, done_cyc, last_wb_cyc, first_rd_cyc, ovf, wbeats;
  logic [LW-1:0] wd_at_done;
  logic [1:0]    st_at_done;
  logic          busy_at_done;

  // Runs one job with both readies high; the bench plays both controllers and
  // the FIFO (one beat per cycle each) and logs every command it sees.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                         input logic [LW-1:0] n, input int glitch, input int max_cyc);
    int rl, wl, fcnt, cyc;
    rl = 0; wl = 0; fcnt = 0;
    n_rd = 0; n_wr = 0; n_done = 0; ovf = 0; wbeats = 0;
    done_cyc = -1; last_wb_cyc = -1; first_rd_cyc = -1;
    wd_at_done = '0; st_at_done = 2'd3; busy_at_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_a[i] = '0; wr_a[i] = '0; rd_l[i] = '0; wr_l[i] = '0;
    end
    rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;
    rd_beat = 1'b0; wr_beat = 1'b0; fifo_usedw = '0;
    src_base = s; dst_base = d; len_words = n; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc < max_cyc && !(n_done > 0 && cyc >= done_cyc + 2)) begin
      fcnt = fcnt + int'(rd_beat) - int'(wr_beat);
      if (fcnt < 0 || fcnt > DEPTH) ovf++;
      fifo_usedw = 10'(fcnt);
      if (rd_cmd_valid) begin
        if (n_rd < 8) begin rd_a[n_rd] = rd_cmd_addr; rd_l[n_rd] = rd_cmd_len; end
        if (n_rd == 0) first_rd_cyc = cyc;
        n_rd++;
      end
      if (wr_cmd_valid) begin
        if (n_wr < 8) begin wr_a[n_wr] = wr_cmd_addr; wr_l[n_wr] = wr_cmd_len; end
        n_wr++;
      end
      if (done) begin
        n_done++; done_cyc = cyc;
        wd_at_done = words_done; st_at_done = state; busy_at_done = busy;
      end
      start = (cyc == glitch);
      if (cyc == glitch) begin
        src_base = 32'hDEAD_0000; dst_base = 32'hBEEF_0000; len_words = 3;
      end
      rd_beat = (rl > 0);
      if (rl > 0) rl--;
      wr_beat = (wl > 0 && fcnt > 0);
      if (wr_beat) begin wl--; wbeats++; last_wb_cyc = cyc; end
      if (rd_cmd_valid) rl += int'(rd_cmd_len);
      if (wr_cmd_valid) wl += int'(wr_cmd_len);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; rd_beat = 1'b0; wr_beat = 1'b0; fifo_usedw = '0;
  endtask

  task automatic chk_job(input string tag, input int nrd, input int nwr, input int words);
    chk({tag, "_n_rd"}, 32'(n_rd), 32'(nrd));
    chk({tag, "_n_wr"}, 32'(n_wr), 32'(nwr));
    chk({tag, "_first_rd_lat"}, 32'(first_rd_cyc), 32'd2);
    chk({tag, "_wr_beats"}, 32'(wbeats), 32'(words));
    chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    chk({tag, "_done_after_last_beat"}, 32'(done_cyc), 32'(last_wb_cyc + 1));
    chk({tag, "_words_done"}, 32'(wd_at_done), 32'(words));
    chk({tag, "_state_at_done"}, 32'(st_at_done), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, "_fifo_bounds"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; len_words = '0; fifo_usedw = '0;
    rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0; rd_beat = 1'b0; wr_beat = 1'b0;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_rd_valid", 32'(rd_cmd_valid), 32'd0);
    chk("rst_wr_valid", 32'(wr_cmd_valid), 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 20-word job, both channels streaming
    run_job(32'h0000_1000, 32'h0000_8000, 20, -1, 300);
    chk("t1_rd0_addr", rd_a[0], 32'h0000_1000); chk("t1_rd0_len", 32'(rd_l[0]), 32'd8);
    chk("t1_rd1_addr", rd_a[1], 32'h0000_1020); chk("t1_rd1_len", 32'(rd_l[1]), 32'd8);
    chk("t1_rd2_addr", rd_a[2], 32'h0000_1040); chk("t1_rd2_len", 32'(rd_l[2]), 32'd4);
    chk("t1_wr0_addr", wr_a[0], 32'h0000_8000); chk("t1_wr0_len", 32'(wr_l[0]), 32'd8);
    chk("t1_wr1_addr", wr_a[1], 32'h0000_8020); chk("t1_wr1_len", 32'(wr_l[1]), 32'd8);
    chk("t1_wr2_addr", wr_a[2], 32'h0000_8040); chk("t1_wr2_len", 32'(wr_l[2]), 32'd4);
    chk_job("t1", 3, 3, 20);

    // FIFO credit gating at the 512-word boundary, commands held while stalled
    fifo_usedw = 10'd506; rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0;
    src_base = 32'h0000_5000; dst_base = 32'h0000_C000; len_words = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_no_credit_506", 32'(rd_cmd_valid), 32'd0);
    end
    fifo_usedw = 10'd505;
    @(negedge clk);
    chk("t2_no_credit_505", 32'(rd_cmd_valid), 32'd0);
    fifo_usedw = 10'd504;
    @(negedge clk);
    chk("t2_credit_504_valid", 32'(rd_cmd_valid), 32'd1);
    chk("t2_rd_len", 32'(rd_cmd_len), 32'd8);
    chk("t2_rd_addr", rd_cmd_addr, 32'h0000_5000);
    chk("t2_wr_valid", 32'(wr_cmd_valid), 32'd1);
    chk("t2_wr_addr", wr_cmd_addr, 32'h0000_C000);
    fifo_usedw = 10'd0;
    @(negedge clk);
    chk("t2_hold_valid", 32'(rd_cmd_valid), 32'd1);
    chk("t2_hold_addr", rd_cmd_addr, 32'h0000_5000);
    chk("t2_hold_len", 32'(rd_cmd_len), 32'd8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t2_abort_state", 32'(state), 32'd3);
    chk("t2_abort_rd_drop", 32'(rd_cmd_valid), 32'd0);
    chk("t2_abort_wr_drop", 32'(wr_cmd_valid), 32'd0);
    @(negedge clk);
    chk("t2_abort_idle", 32'(state), 32'd0);
    chk("t2_aborted", 32'(aborted), 32'd1);
    chk("t2_no_done", 32'(done), 32'd0);

    // zero length with a simultaneous abort: start wins, one busy cycle, then done
    rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;
    len_words = 0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_state_run", 32'(state), 32'd1);
    chk("t3_aborted_clr", 32'(aborted), 32'd0);
    chk("t3_rd_valid", 32'(rd_cmd_valid), 32'd0);
    chk("t3_wr_valid", 32'(wr_cmd_valid), 32'd0);
    @(negedge clk);
    chk("t3_busy_end", 32'(busy), 32'd0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_state_idle", 32'(state), 32'd0);
    chk("t3_rd_valid2", 32'(rd_cmd_valid), 32'd0);
    @(negedge clk);
    chk("t3_done_pulse", 32'(done), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_state", 32'(state), 32'd0);
    chk("idle_abort_flag", 32'(aborted), 32'd0);

    // abort with five read beats still outstanding
    fifo_usedw = '0;
    src_base = 32'h0000_2000; dst_base = 32'h0000_9000; len_words = 16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !rd_cmd_valid; i++) @(negedge clk);
    chk("t4_rd_valid", 32'(rd_cmd_valid), 32'd1);
    chk("t4_rd_addr", rd_cmd_addr, 32'h0000_2000);
    chk("t4_rd_len", 32'(rd_cmd_len), 32'd8);
    @(negedge clk);
    chk("t4_valid_drop_after_hs", 32'(rd_cmd_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin rd_beat = 1'b1; @(negedge clk); end
    rd_beat = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_state", 32'(state), 32'd3);
    for (int i = 0; i < 4; i++) begin
      rd_beat = 1'b1;
      @(negedge clk);
      chk("t4_abort_wait", 32'(state), 32'd3);
      chk("t4_abort_no_cmd", 32'(rd_cmd_valid), 32'd0);
    end
    rd_beat = 1'b1;
    @(negedge clk);
    rd_beat = 1'b0;
    chk("t4_abort_idle", 32'(state), 32'd0);
    chk("t4_aborted", 32'(aborted), 32'd1);
    chk("t4_no_done", 32'(done), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);

    // reset while a read command is waiting
    rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0; fifo_usedw = '0;
    src_base = 32'h0000_6000; dst_base = 32'h0000_D000; len_words = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !rd_cmd_valid; i++) @(negedge clk);
    chk("t6_rd_valid_pre", 32'(rd_cmd_valid), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rd_valid", 32'(rd_cmd_valid), 32'd0);
    chk("t6_rd_addr", rd_cmd_addr, 32'd0);
    chk("t6_rd_len", 32'(rd_cmd_len), 32'd0);
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_aborted", 32'(aborted), 32'd0);
    reset = 1'b1;
    rd_beat = 1'b1; wr_beat = 1'b1;
    @(negedge clk);
    rd_beat = 1'b0; wr_beat = 1'b0;
    chk("t6_stray_beat_words", 32'(words_done), 32'd0);
    chk("t6_stray_beat_state", 32'(state), 32'd0);
    run_job(32'h0000_3000, 32'h0000_B000, 4, -1, 200);
    chk("t6_rd0_addr", rd_a[0], 32'h0000_3000); chk("t6_rd0_len", 32'(rd_l[0]), 32'd4);
    chk("t6_wr0_addr", wr_a[0], 32'h0000_B000); chk("t6_wr0_len", 32'(wr_l[0]), 32'd4);
    chk_job("t6", 1, 1, 4);

    // start pulse during RUN must not disturb the job
    run_job(32'h0000_4000, 32'h0000_A000, 12, 5, 300);
    chk("t5_rd0_addr", rd_a[0], 32'h0000_4000); chk("t5_rd0_len", 32'(rd_l[0]), 32'd8);
    chk("t5_rd1_addr", rd_a[1], 32'h0000_4020); chk("t5_rd1_len", 32'(rd_l[1]), 32'd4);
    chk("t5_wr0_addr", wr_a[0], 32'h0000_A000); chk("t5_wr0_len", 32'(wr_l[0]), 32'd8);
    chk("t5_wr1_addr", wr_a[1], 32'h0000_A020); chk("t5_wr1_len", 32'(wr_l[1]), 32'd4);
    chk_job("t5", 2, 2, 12);

    // 32-bit address wrap
    run_job(32'hFFFF_FFF0, 32'hFFFF_FFE0, 16, -1, 300);
    chk("t7_rd0_addr", rd_a[0], 32'hFFFF_FFF0);
    chk("t7_rd1_addr", rd_a[1], 32'h0000_0010);
    chk("t7_wr0_addr", wr_a[0], 32'hFFFF_FFE0);
    chk("t7_wr1_addr", wr_a[1], 32'h0000_0000);
    chk_job("t7", 2, 2, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
